rf_sequencer: RTL and testbench

// Synthesizable master for the 8x4 two-read/one-write register_file. Drives all
// RF ports and returns read data to the requester. Accepts commands over a

---
 rtl/rf_seq_pkg.sv | 24 ++
 rtl/rf_seq_out_reg.sv | 40 ++++
 rtl/rf_sequencer.sv | 160 ++++++++++++++++
 tb/tb_rf_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_seq_pkg.sv
// Shared types and default sizes for the register-file sequencer and the
// 8x4 register_file it drives.
package rf_seq_pkg;

   localparam int RF_DATA_W   = 4;
   localparam int RF_ADDR_W   = 3;
   localparam int RF_NUM_REGS = 8;

   typedef enum logic [1:0] {
      OP_WRITE     = 2'b00,
      OP_READ_PAIR = 2'b01,
      OP_FILL      = 2'b10,
      OP_DUMP      = 2'b11
   } rf_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_FILL,
      ST_RD,
      ST_OUT
   } rf_state_e;

endpackage

// File: rtl/rf_seq_out_reg.sv
// Result holding register: loads one beat, keeps it stable until the
// consumer takes it with valid && ready.
module rf_seq_out_reg #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data1,
   input  logic [DATA_W-1:0] load_data2,
   input  logic              load_last,
   input  logic              ready,
   output logic              valid,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data1,
   output logic [DATA_W-1:0] data2,
   output logic              last
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         addr  <= '0;
         data1 <= '0;
         data2 <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         addr  <= load_addr;
         data1 <= load_data1;
         data2 <= load_data2;
         last  <= load_last;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/rf_sequencer.sv
// Command-driven master for the two-read/one-write register file: single
// write, pair read, fill-all and full dump, with results on a valid/ready port.
module rf_sequencer
   import rf_seq_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_REGS = RF_NUM_REGS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data1,
   output logic [DATA_W-1:0] out_data2,
   output logic              out_last,
   output logic              busy,
   output logic [ADDR_W-1:0] rf_read_address1,
   output logic [ADDR_W-1:0] rf_read_address2,
   output logic [ADDR_W-1:0] rf_write_address,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_write_enable,
   input  logic [DATA_W-1:0] rf_read_data1,
   input  logic [DATA_W-1:0] rf_read_data2,
   output rf_state_e         state
);

   // Handshakes: a command transfers on the edge where cmd_valid && cmd_ready;
   // a result beat transfers on the edge where out_valid && out_ready.
   rf_state_e         state_next;
   rf_op_e            op;
   logic              accept;
   logic              out_load;
   logic              out_fire;
   logic              advance;
   logic              dump;
   logic              fill_done;
   logic [ADDR_W-1:0] cnt;

   assign op        = rf_op_e'(cmd_op);
   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign out_fire  = out_valid && out_ready;
   assign fill_done = (cnt == ADDR_W'(NUM_REGS - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next      = state;
      accept          = 1'b0;
      out_load        = 1'b0;
      advance         = 1'b0;
      rf_write_enable = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               accept = 1'b1;
               unique case (op)
                  OP_WRITE:             state_next = ST_WR;
                  OP_FILL:              state_next = ST_FILL;
                  OP_READ_PAIR, OP_DUMP: state_next = ST_RD;
                  default:              state_next = ST_IDLE;
               endcase
            end
         end
         ST_WR: begin
            rf_write_enable = 1'b1;
            state_next      = ST_IDLE;
         end
         ST_FILL: begin
            rf_write_enable = 1'b1;
            if (fill_done) state_next = ST_IDLE;
         end
         ST_RD: begin
            out_load   = 1'b1;
            state_next = ST_OUT;
         end
         ST_OUT: begin
            if (out_fire) begin
               advance    = dump && !out_last;
               state_next = advance ? ST_RD : ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Address/data registers hold their last value whenever nothing updates them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dump             <= 1'b0;
         cnt              <= '0;
         rf_read_address1 <= '0;
         rf_read_address2 <= '0;
         rf_write_address <= '0;
         rf_write_data    <= '0;
      end else begin
         if (accept) begin
            dump <= (op == OP_DUMP);
            unique case (op)
               OP_WRITE: begin
                  rf_write_address <= cmd_addr;
                  rf_write_data    <= cmd_data;
               end
               OP_FILL: begin
                  cnt              <= '0;
                  rf_write_address <= '0;
                  rf_write_data    <= cmd_data;
               end
               OP_READ_PAIR: begin
                  rf_read_address1 <= cmd_addr;
                  rf_read_address2 <= cmd_addr + ADDR_W'(1);
               end
               OP_DUMP: begin
                  rf_read_address1 <= '0;
                  rf_read_address2 <= ADDR_W'(1);
               end
               default: ;
            endcase
         end
         if (state == ST_FILL && !fill_done) begin
            cnt              <= cnt + ADDR_W'(1);
            rf_write_address <= cnt + ADDR_W'(1);
         end
         if (advance) begin
            rf_read_address1 <= rf_read_address1 + ADDR_W'(2);
            rf_read_address2 <= rf_read_address2 + ADDR_W'(2);
         end
      end
   end

   rf_seq_out_reg #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_out_reg (
      .clk        (clk),
      .reset      (reset),
      .load       (out_load),
      .load_addr  (rf_read_address1),
      .load_data1 (rf_read_data1),
      .load_data2 (rf_read_data2),
      .load_last  (!dump || (rf_read_address1 == ADDR_W'(NUM_REGS - 2))),
      .ready      (out_ready),
      .valid      (out_valid),
      .addr       (out_addr),
      .data1      (out_data1),
      .data2      (out_data2),
      .last       (out_last)
   );

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer with a behavioural 8x4 register file attached;
// results are checked against a register-array model of the command set.
module tb_rf_sequencer;
   import rf_seq_pkg::*;

   localparam int DW = RF_DATA_W;
   localparam int AW = RF_ADDR_W;
   localparam int NR = RF_NUM_REGS;
   localparam int W  = AW + 2 * DW + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic          out_valid, out_ready, out_last, busy;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data1, out_data2;
   logic [AW-1:0] rf_read_address1, rf_read_address2, rf_write_address;
   logic [DW-1:0] rf_write_data, rf_read_data1, rf_read_data2;
   logic          rf_write_enable;
   rf_state_e     state;

   logic [DW-1:0] rf_mem [NR];
   logic [DW-1:0] model [NR];
   logic [W-1:0]  exp_q [$];
   int            n_cmp = 0;
   int            n_err = 0;

   typedef struct {
      rf_op_e op;
      int     a;
      int     d;
      bit     has_exp;
      int     ea;
      int     e1;
      int     e2;
   } vec_t;
   vec_t vecs [7];

   // ---------------- clock / reset / RF ----------------
   always #5 clk = ~clk;

   always @(posedge clk) if (rf_write_enable) rf_mem[rf_write_address] <= rf_write_data;
   assign rf_read_data1 = rf_mem[rf_read_address1];
   assign rf_read_data2 = rf_mem[rf_read_address2];

   rf_sequencer dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data1(out_data1), .out_data2(out_data2), .out_last(out_last),
      .busy(busy),
      .rf_read_address1(rf_read_address1), .rf_read_address2(rf_read_address2),
      .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
      .rf_write_enable(rf_write_enable),
      .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
      .state(state)
   );

   // ---------------- model / scoreboard ----------------
   function automatic logic [W-1:0] beat(input int a, input int d1, input int d2, input bit last);
      logic [AW-1:0] aa;
      logic [DW-1:0] x1, x2;
      aa = a[AW-1:0];
      x1 = d1[DW-1:0];
      x2 = d2[DW-1:0];
      return {aa, x1, x2, last};
   endfunction

   task automatic model_cmd(input rf_op_e op, input int a, input int d);
      case (op)
         OP_WRITE:     model[a] = d[DW-1:0];
         OP_FILL:      for (int i = 0; i < NR; i++) model[i] = d[DW-1:0];
         OP_READ_PAIR: exp_q.push_back(beat(a, model[a], model[(a + 1) % NR], 1'b1));
         OP_DUMP:      for (int p = 0; p < NR; p += 2)
                          exp_q.push_back(beat(p, model[p], model[p + 1], p == NR - 2));
         default: ;
      endcase
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_we"}, rf_write_enable, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_cmd_ready"}, cmd_ready, 1);
      check({tag, "_ra1"}, rf_read_address1, 0);
      check({tag, "_ra2"}, rf_read_address2, 0);
      check({tag, "_wa"}, rf_write_address, 0);
   endtask

   // ---------------- drivers ----------------
   task automatic send_cmd(input rf_op_e op, input int a, input int d);
      int t;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a[AW-1:0];
      cmd_data  = d[DW-1:0];
      t = 0;
      while (!cmd_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) check("cmd_accept_timeout", cmd_ready, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic get_beat(input string name, input int stall);
      int t;
      logic [W-1:0] e;
      out_ready = 1'b0;
      @(negedge clk);
      t = 0;
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) begin
         check({name, "_timeout"}, out_valid, 1);
         return;
      end
      repeat (stall) @(negedge clk);
      if (exp_q.size() == 0) begin
         check({name, "_unexpected_beat"}, 1, 0);
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      check(name, {out_addr, out_data1, out_data2, out_last}, e);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic drain(input string name);
      while (exp_q.size() > 0) get_beat(name, $urandom_range(0, 2));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] snap;
      int k, t;
      rf_op_e rop;

      vecs[0] = '{OP_WRITE,     5, 9,    0, 0, 0,    0};
      vecs[1] = '{OP_READ_PAIR, 5, 0,    1, 5, 9,    4'hA};
      vecs[2] = '{OP_READ_PAIR, 7, 0,    1, 7, 4'hA, 4'hA};
      vecs[3] = '{OP_WRITE,     0, 3,    0, 0, 0,    0};
      vecs[4] = '{OP_READ_PAIR, 7, 0,    1, 7, 4'hA, 3};
      vecs[5] = '{OP_WRITE,     7, 4'hC, 0, 0, 0,    0};
      vecs[6] = '{OP_READ_PAIR, 6, 0,    1, 6, 4'hA, 4'hC};

      reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("por");
      check("por_state", state, ST_IDLE);
      reset = 1'b1;

      // Fill with A: exactly eight write cycles on addresses 0..7, then dump.
      send_cmd(OP_FILL, 0, 4'hA);
      model_cmd(OP_FILL, 0, 4'hA);
      k = 0;
      repeat (12) begin
         @(negedge clk);
         if (rf_write_enable) begin
            check("fill_addr", rf_write_address, k);
            check("fill_data", rf_write_data, 4'hA);
            k++;
         end
      end
      check("fill_we_cycles", k, 8);
      send_cmd(OP_DUMP, 0, 0);
      model_cmd(OP_DUMP, 0, 0);
      drain("fill_dump_beat");

      // Table of writes and pair reads, including the 7 -> 0 wrap.
      for (int i = 0; i < 7; i++) begin
         send_cmd(vecs[i].op, vecs[i].a, vecs[i].d);
         if (vecs[i].has_exp) begin
            check("tbl_ra1", rf_read_address1, vecs[i].a);
            check("tbl_ra2", rf_read_address2, (vecs[i].a + 1) % NR);
            exp_q.push_back(beat(vecs[i].ea, vecs[i].e1, vecs[i].e2, 1'b1));
            get_beat("tbl_read", i % 3);
         end else begin
            model_cmd(vecs[i].op, vecs[i].a, vecs[i].d);
         end
      end

      // Dump with beat 2 stalled for five cycles.
      send_cmd(OP_DUMP, 0, 0);
      model_cmd(OP_DUMP, 0, 0);
      get_beat("stall_beat0", 0);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      snap = {out_addr, out_data1, out_data2, out_last};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", out_valid, 1);
         check("stall_addr", out_addr, 2);
         check("stall_stable", {out_addr, out_data1, out_data2, out_last}, snap);
         check("stall_ra1", rf_read_address1, 2);
      end
      drain("stall_beat");

      // Reset pulse in the middle of a dump.
      send_cmd(OP_DUMP, 0, 0);
      model_cmd(OP_DUMP, 0, 0);
      get_beat("mid_beat0", 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1 check_reset("mid");
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;

      // Fill cut short by reset after three write cycles.
      send_cmd(OP_FILL, 0, 5);
      model_cmd(OP_FILL, 0, 5);
      @(negedge clk);
      while (busy) @(negedge clk);
      send_cmd(OP_FILL, 0, 3);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) model[i] = 3;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("fillrst_state", state, ST_IDLE);
      check("fillrst_cmd_ready", cmd_ready, 1);
      check("fillrst_busy", busy, 0);
      send_cmd(OP_DUMP, 0, 0);
      model_cmd(OP_DUMP, 0, 0);
      drain("fillrst_dump");

      // Back-to-back commands with cmd_valid held high.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 1; cmd_data = 6;
      @(posedge clk);
      #1 cmd_op = OP_READ_PAIR; cmd_addr = 0; cmd_data = 0;
      model_cmd(OP_WRITE, 1, 6);
      @(negedge clk);
      check("b2b_ready_wr", cmd_ready, 0);
      t = 0;
      while (!cmd_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      model_cmd(OP_READ_PAIR, 0, 0);
      @(negedge clk);
      check("b2b_ready_rd", cmd_ready, 0);
      @(negedge clk);
      check("b2b_ready_out", cmd_ready, 0);
      check("b2b_out_valid", out_valid, 1);
      get_beat("b2b_read", 0);

      // Random commands against the model.
      repeat (40) begin
         rop = rf_op_e'($urandom_range(0, 3));
         k   = $urandom_range(0, NR - 1);
         t   = $urandom_range(0, 15);
         send_cmd(rop, k, t);
         model_cmd(rop, k, t);
         drain("rand_beat");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
